// File: rtl/alu_rr_arbiter_if.sv
// Request/response and shared-ALU bundle for the round-robin ALU arbiter.
// master = requesters plus ALU side, slave = the arbiter itself.
interface alu_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int OP_W    = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_opcode;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [OP_W-1:0]           alu_opcode;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [DATA_W-1:0]         alu_result;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_err;

  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_result, rsp_ready,
    input  req_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters.
// One transaction in flight: IDLE(grant) -> LOAD -> CAPT -> RESP.
module alu_rr_arbiter #(
  parameter int              NUM_REQ = 4,
  parameter int              DATA_W  = 4,
  parameter int              OP_W    = 4,
  parameter logic [OP_W-1:0] IDLE_OP = {OP_W{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  alu_rr_arbiter_if.slave    bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CAPT, S_RESP} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [OP_W-1:0]   lat_op_reg;
  logic [DATA_W-1:0] lat_a_reg, lat_b_reg;
  logic [ID_W-1:0]   lat_id_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic [DATA_W-1:0] rsp_result_reg;
  logic              rsp_err_reg;

  logic [OP_W-1:0]    op_arr [NUM_REQ];
  logic [DATA_W-1:0]  a_arr  [NUM_REQ];
  logic [DATA_W-1:0]  b_arr  [NUM_REQ];
  logic               grant_hit;
  logic [ID_W-1:0]    grant_idx;
  logic               unsupported;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [OP_W-1:0]    alu_opcode_c;
  logic               rsp_valid_c;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_arr[gi] = bus.req_opcode[gi*OP_W +: OP_W];
      assign a_arr[gi]  = bus.req_a[gi*DATA_W +: DATA_W];
      assign b_arr[gi]  = bus.req_b[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Walk backwards so the nearest valid index at or after rr_ptr wins.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req_valid[idx]) begin
        grant_hit = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  assign unsupported = (lat_op_reg > OP_W'(3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (grant_hit) state_next = S_LOAD;
      S_LOAD:  state_next = S_CAPT;
      S_CAPT:  state_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_c  = '0;
    alu_opcode_c = IDLE_OP;
    rsp_valid_c  = 1'b0;
    case (state_reg)
      S_IDLE:  if (grant_hit) req_ready_c[grant_idx] = 1'b1;
      S_LOAD,
      S_CAPT:  alu_opcode_c = lat_op_reg;
      S_RESP:  rsp_valid_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg     <= '0;
      lat_op_reg     <= IDLE_OP;
      lat_a_reg      <= '0;
      lat_b_reg      <= '0;
      lat_id_reg     <= '0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_err_reg    <= 1'b0;
    end else begin
      if (state_reg == S_IDLE && grant_hit) begin
        lat_op_reg <= op_arr[grant_idx];
        lat_a_reg  <= a_arr[grant_idx];
        lat_b_reg  <= b_arr[grant_idx];
        lat_id_reg <= grant_idx;
      end
      // Unsupported opcodes never loaded the ALU, so its output is meaningless.
      if (state_reg == S_CAPT) begin
        rsp_result_reg <= unsupported ? '0 : bus.alu_result;
        rsp_err_reg    <= unsupported;
        rsp_id_reg     <= lat_id_reg;
      end
      if (state_reg == S_RESP && bus.rsp_ready) begin
        rr_ptr_reg <= (int'(lat_id_reg) == NUM_REQ - 1) ? '0 : ID_W'(lat_id_reg + 1'b1);
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.alu_opcode = alu_opcode_c;
  assign bus.alu_a      = lat_a_reg;
  assign bus.alu_b      = lat_b_reg;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.rsp_id     = rsp_id_reg;
  assign bus.rsp_result = rsp_result_reg;
  assign bus.rsp_err    = rsp_err_reg;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: table vectors, hand sequences for round-robin/reset,
// and randomized transactions against a transaction-level reference model.
module tb_alu_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) bus ();

  alu_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .IDLE_OP(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared ALU: loads on an edge only for opcodes 0..3, result combinational.
  logic [3:0] alu_ra, alu_rb;
  always @(posedge clk) begin
    if (bus.alu_opcode <= 4'd3) begin
      alu_ra <= bus.alu_a;
      alu_rb <= bus.alu_b;
    end
  end
  always_comb begin
    case (bus.alu_opcode)
      4'd0:    bus.alu_result = alu_ra + alu_rb;
      4'd1:    bus.alu_result = alu_ra - alu_rb;
      4'd2:    bus.alu_result = alu_ra & alu_rb;
      4'd3:    bus.alu_result = alu_ra | alu_rb;
      default: bus.alu_result = 4'h9;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m = 0;
  logic [3:0] op_t [N];
  logic [3:0] a_t  [N];
  logic [3:0] b_t  [N];

  typedef struct {
    int         id;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       err;
    int         delay;
  } vec_t;

  function automatic logic [3:0] ref_alu(input logic [3:0] op, a, b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      default: return 4'h0;
    endcase
  endfunction

  function automatic int model_grant(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fields;
    for (int i = 0; i < N; i++) begin
      bus.req_opcode[i*OW +: OW] = op_t[i];
      bus.req_a[i*DW +: DW]      = a_t[i];
      bus.req_b[i*DW +: DW]      = b_t[i];
    end
  endtask

  task automatic do_reset;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) tick;
    rst = 1'b0;
    ptr_m = 0;
    tick;
  endtask

  // Issue one request set from IDLE and follow it to the response handshake.
  task automatic run_txn(input logic [N-1:0] mask, input int exp_g,
                         input logic [3:0] exp_res, input logic exp_err, input int delay);
    int n;
    drive_fields();
    bus.req_valid = mask;
    bus.rsp_ready = 1'b0;
    #1;
    chk("grant_ready", 32'(bus.req_ready), 32'(1 << exp_g));
    chk("idle_alu_op", 32'(bus.alu_opcode), 32'hF);
    tick;
    bus.req_valid = '0;
    bus.rsp_ready = (delay == 0);
    #1;
    chk("load_ready", 32'(bus.req_ready), 32'h0);
    chk("load_alu_op", 32'(bus.alu_opcode), 32'(op_t[exp_g]));
    chk("load_alu_a", 32'(bus.alu_a), 32'(a_t[exp_g]));
    tick;
    chk("capt_alu_op", 32'(bus.alu_opcode), 32'(op_t[exp_g]));
    chk("capt_valid", 32'(bus.rsp_valid), 32'h0);
    n = 2;
    do begin
      tick;
      n++;
    end while (!bus.rsp_valid && n < 10);
    chk("latency", 32'(n), 32'd3);
    chk("rsp_id", 32'(bus.rsp_id), 32'(exp_g));
    chk("rsp_result", 32'(bus.rsp_result), 32'(exp_res));
    chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
    chk("resp_alu_op", 32'(bus.alu_opcode), 32'hF);
    if (delay > 0) begin
      bus.req_valid = mask;
      for (int d = 0; d < delay; d++) begin
        tick;
        chk("hold_valid", 32'(bus.rsp_valid), 32'h1);
        chk("hold_result", 32'(bus.rsp_result), 32'(exp_res));
        chk("hold_id", 32'(bus.rsp_id), 32'(exp_g));
        chk("hold_ready", 32'(bus.req_ready), 32'h0);
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
    end
    tick;
    bus.rsp_ready = 1'b0;
    #1;
    chk("post_hs_valid", 32'(bus.rsp_valid), 32'h0);
    tick;
    chk("single_hs", 32'(bus.rsp_valid), 32'h0);
    ptr_m = (exp_g + 1) % N;
    $display("txn grant=%0d op=%0h a=%0h b=%0h result=%0h err=%0b",
             exp_g, op_t[exp_g], a_t[exp_g], b_t[exp_g], bus.rsp_result, bus.rsp_err);
  endtask

  vec_t vecs [8];
  int   rr_order [8];
  logic [N-1:0] rr_mask [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 4'h0, 4'h3, 4'h4, 4'h7, 1'b0, 0};
    vecs[1] = '{2, 4'h1, 4'h2, 4'h5, 4'hD, 1'b0, 1};
    vecs[2] = '{2, 4'h0, 4'hF, 4'h1, 4'h0, 1'b0, 0};
    vecs[3] = '{1, 4'h7, 4'h5, 4'h5, 4'h0, 1'b1, 2};
    vecs[4] = '{3, 4'h2, 4'hC, 4'hA, 4'h8, 1'b0, 0};
    vecs[5] = '{3, 4'h3, 4'hC, 4'hA, 4'hE, 1'b0, 1};
    vecs[6] = '{1, 4'h1, 4'h0, 4'h1, 4'hF, 1'b0, 5};
    vecs[7] = '{0, 4'hF, 4'h1, 4'h2, 4'h0, 1'b1, 0};
    rr_order = '{0, 1, 2, 3, 0, 1, 3, 1};
    rr_mask  = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hA, 4'hA, 4'hA};

    for (int i = 0; i < N; i++) begin
      op_t[i] = 4'h0; a_t[i] = 4'h0; b_t[i] = 4'h0;
    end
    drive_fields();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick;
    chk("rst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_id", 32'(bus.rsp_id), 32'h0);
    chk("rst_result", 32'(bus.rsp_result), 32'h0);
    chk("rst_err", 32'(bus.rsp_err), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_alu_op", 32'(bus.alu_opcode), 32'hF);
    chk("rst_alu_a", 32'(bus.alu_a), 32'h0);
    chk("rst_alu_b", 32'(bus.alu_b), 32'h0);
    rst = 1'b0;
    tick;

    // Single-requester vectors with fixed expected outputs.
    foreach (vecs[v]) begin
      op_t[vecs[v].id] = vecs[v].op;
      a_t[vecs[v].id]  = vecs[v].a;
      b_t[vecs[v].id]  = vecs[v].b;
      run_txn(4'(1 << vecs[v].id), vecs[v].id, vecs[v].res, vecs[v].err, vecs[v].delay);
    end

    // Round-robin order from reset, then only req1/req3 valid.
    do_reset();
    for (int i = 0; i < N; i++) begin
      op_t[i] = 4'(i % 4); a_t[i] = 4'(i + 5); b_t[i] = 4'(2 * i + 1);
    end
    foreach (rr_order[k]) begin
      run_txn(rr_mask[k], rr_order[k],
              ref_alu(op_t[rr_order[k]], a_t[rr_order[k]], b_t[rr_order[k]]), 1'b0, k % 2);
    end

    // Reset while in CAPT discards the transaction and rewinds rr_ptr.
    drive_fields();
    bus.req_valid = 4'hF;
    #1;
    chk("pre_rst_grant", 32'(bus.req_ready), 32'(1 << ptr_m));
    tick;
    bus.req_valid = '0;
    tick;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_capt_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_capt_alu_op", 32'(bus.alu_opcode), 32'hF);
    tick;
    rst = 1'b0;
    ptr_m = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rst_no_rsp", 32'(bus.rsp_valid), 32'h0);
    end
    run_txn(4'hF, 0, ref_alu(op_t[0], a_t[0], b_t[0]), 1'b0, 0);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] mask;
      int g;
      for (int i = 0; i < N; i++) begin
        op_t[i] = 4'($urandom_range(0, 5));
        a_t[i]  = 4'($urandom);
        b_t[i]  = 4'($urandom);
      end
      mask = 4'($urandom_range(1, 15));
      g = model_grant(mask);
      run_txn(mask, g, ref_alu(op_t[g], a_t[g], b_t[g]), op_t[g] > 4'd3,
              int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
